// File: rtl/perif_es_pkg.sv
// Shared address map and status-word layout for the perif_es memory-mapped I/O responder.
// Also provides the offset-to-region decode used by the top level.
package perif_es_pkg;

  localparam logic [3:0] OFF_OUT0 = 4'h0;
  localparam logic [3:0] OFF_OUT1 = 4'h1;
  localparam logic [3:0] OFF_OUT2 = 4'h2;
  localparam logic [3:0] OFF_OUT3 = 4'h3;
  localparam logic [3:0] OFF_FIFO = 4'h4;
  localparam logic [3:0] OFF_STAT = 4'h5;
  localparam logic [3:0] OFF_RAW  = 4'h6;

  localparam int STAT_NEMPTY = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_CNT_LO = 2;
  localparam int STAT_CNT_HI = 4;
  localparam int STAT_UND    = 5;

  typedef enum logic [2:0] {
    R_NONE,
    R_OUT,
    R_FIFO,
    R_STAT,
    R_RAW
  } region_e;

  function automatic region_e decode_region(input logic [3:0] off);
    case (off)
      OFF_OUT0, OFF_OUT1, OFF_OUT2, OFF_OUT3: return R_OUT;
      OFF_FIFO: return R_FIFO;
      OFF_STAT: return R_STAT;
      OFF_RAW:  return R_RAW;
      default:  return R_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fifo_es.sv
// Synchronous FIFO with extra-bit pointers; head word is presented combinationally on dout.
// push/pop requests against a full/empty FIFO are ignored.
module fifo_es #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; contents are meaningless until written and the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/perif_es.sv
// Memory-mapped I/O responder: four output registers, an input FIFO, a status word and a
// synchronised raw input. Reads are combinational; all side effects commit at the clock edge.
module perif_es
  import perif_es_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter int          DEPTH = 4,
  parameter logic [11:0] BASE  = 12'hFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          direcciones,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 we,
  input  logic                 re,
  output logic [WIDTH-1:0]     datos,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_raw,
  output logic [4*WIDTH-1:0]   out_ports
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             sel;
  logic [3:0]       off;
  region_e          region;
  logic             rd;
  logic             wr;

  logic [WIDTH-1:0] out_reg [4];
  logic             und;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  logic             fifo_push;
  logic             fifo_pop;
  logic             und_set;
  logic             und_clr;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] status;

  assign sel    = (direcciones[15:4] == BASE);
  assign off    = direcciones[3:0];
  assign region = decode_region(off);
  assign rd     = sel && re;
  assign wr     = sel && we;

  // Ready drops while reset is held so the producer never sees a phantom accept.
  assign in_ready  = !fifo_full && reset;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = rd && (region == R_FIFO) && !fifo_empty;
  assign und_set   = rd && (region == R_FIFO) && fifo_empty;
  assign und_clr   = wr && (region == R_STAT);

  fifo_es #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) out_reg[k] <= '0;
    end else if (wr && (region == R_OUT)) begin
      out_reg[off[1:0]] <= wdata;
    end
  end

  // A status write clears the sticky underflow even if an underflow arrives in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      und <= 1'b0;
    end else if (und_clr) begin
      und <= 1'b0;
    end else if (und_set) begin
      und <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_raw;
      sync2 <= sync1;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    status                           = '0;
    status[STAT_NEMPTY]              = !fifo_empty;
    status[STAT_FULL]                = fifo_full;
    status[STAT_CNT_HI:STAT_CNT_LO]  = 3'(fifo_count);
    status[STAT_UND]                 = und;
  end

  always_comb begin
    datos = '0;
    if (rd) begin
      case (region)
        R_OUT:   datos = out_reg[off[1:0]];
        R_FIFO:  datos = fifo_empty ? '0 : fifo_dout;
        R_STAT:  datos = status;
        R_RAW:   datos = sync2;
        default: datos = '0;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_ports
    assign out_ports[k*WIDTH +: WIDTH] = out_reg[k];
  end

endmodule

// File: tb/tb_perif_es.sv
// Scoreboard bench for perif_es: a queue-based reference model predicts datos, in_ready and
// out_ports for every driven cycle; a negedge monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_perif_es;

  localparam int W = 16;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [15:0]    direcciones;
  logic [W-1:0]   wdata;
  logic           we;
  logic           re;
  logic [W-1:0]   datos;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_raw;
  logic [4*W-1:0] out_ports;

  int n_checks = 0;
  int n_fail   = 0;

  perif_es #(.WIDTH(W), .DEPTH(D), .BASE(12'hFFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .direcciones (direcciones),
    .wdata       (wdata),
    .we          (we),
    .re          (re),
    .datos       (datos),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_raw      (in_raw),
    .out_ports   (out_ports)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   datos;
    logic           rdy;
    logic [4*W-1:0] ports;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_out[4];
  logic         m_und;
  logic [W-1:0] m_raw[$];

  task automatic check(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int k = 0; k < 4; k++) m_out[k] = '0;
    m_und = 1'b0;
    m_raw.delete();
    m_raw.push_back('0);
    m_raw.push_back('0);
  endtask

  function automatic logic [W-1:0] model_status();
    int n = m_q.size();
    return W'((int'(m_und) << 5) | (n << 2) | (int'(n == D) << 1) | int'(n != 0));
  endfunction

  function automatic logic [W-1:0] model_read(input logic [15:0] a, input logic r);
    int o = int'(a[3:0]);
    if (!r || a[15:4] != 12'hFFF) return '0;
    if (o < 4)  return m_out[o];
    if (o == 4) return (m_q.size() > 0) ? m_q[0] : '0;
    if (o == 5) return model_status();
    if (o == 6) return m_raw[0];
    return '0;
  endfunction

  function automatic logic [4*W-1:0] model_ports();
    return {m_out[3], m_out[2], m_out[1], m_out[0]};
  endfunction

  // One bus cycle: drive at posedge+1, predict, advance the model across the next edge.
  task automatic cycle(input logic [15:0] a, input logic [W-1:0] wd, input logic w, input logic r,
                       input logic v, input logic [W-1:0] d, input logic [W-1:0] raw);
    exp_t e;
    logic sel;
    logic rdy;
    int   o;
    direcciones = a; wdata = wd; we = w; re = r;
    in_valid = v; in_data = d; in_raw = raw;
    sel = (a[15:4] == 12'hFFF);
    o   = int'(a[3:0]);
    rdy = (m_q.size() < D);
    e.datos = model_read(a, r);
    e.rdy   = rdy;
    e.ports = model_ports();
    sb.push_back(e);
    if (sel && r && o == 4) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_und = 1'b1;
    end
    if (v && rdy) m_q.push_back(d);
    if (sel && w && o < 4) m_out[o] = wd;
    if (sel && w && o == 5) m_und = 1'b0;
    m_raw.push_back(raw);
    void'(m_raw.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic rd_cyc(input logic [15:0] a);
    cycle(a, '0, 1'b0, 1'b1, 1'b0, '0, in_raw);
  endtask

  task automatic wr_cyc(input logic [15:0] a, input logic [W-1:0] wd);
    cycle(a, wd, 1'b1, 1'b0, 1'b0, '0, in_raw);
  endtask

  task automatic push_cyc(input logic [W-1:0] d);
    cycle(16'h0000, '0, 1'b0, 1'b0, 1'b1, d, in_raw);
  endtask

  // Combinational look at datos without crossing a clock edge.
  task automatic peek(input string name, input logic [15:0] a, input logic [W-1:0] exp);
    direcciones = a; re = 1'b1; we = 1'b0; in_valid = 1'b0;
    #1;
    check(name, 64'(datos), 64'(exp));
    re = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_datos", 64'(datos), 64'(e.datos));
      check("sb_in_ready", 64'(in_ready), 64'(e.rdy));
      check("sb_out_ports", out_ports, e.ports);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    direcciones = '0; wdata = '0; we = 1'b0; re = 1'b0;
    in_data = '0; in_valid = 1'b0; in_raw = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'(0));
    check("reset_out_ports", out_ports, '0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset.
    check("idle_out_ports", out_ports, '0);
    check("idle_in_ready", 64'(in_ready), 64'(1));
    peek("idle_status", 16'hFFF5, 16'h0000);
    rd_cyc(16'hFFF5);

    // Output registers and address select.
    wr_cyc(16'hFFF2, 16'h1234);
    check("out2_written", 64'(out_ports[47:32]), 64'(16'h1234));
    peek("out2_read", 16'hFFF2, 16'h1234);
    wr_cyc(16'h0002, 16'hAAAA);
    check("out2_unsel_write", 64'(out_ports[47:32]), 64'(16'h1234));
    peek("unsel_read", 16'h0002, 16'h0000);

    // Fill the FIFO.
    push_cyc(16'h0011);
    push_cyc(16'h0022);
    push_cyc(16'h0033);
    push_cyc(16'h0044);
    check("full_in_ready", 64'(in_ready), 64'(0));
    peek("full_status", 16'hFFF5, 16'h0013);

    // Pop while full with in_valid high: the push is refused.
    cycle(16'hFFF4, '0, 1'b0, 1'b1, 1'b1, 16'h0055, in_raw);
    peek("pop_full_status", 16'hFFF5, 16'h000D);
    rd_cyc(16'hFFF4);
    rd_cyc(16'hFFF4);
    rd_cyc(16'hFFF4);
    peek("drained_status", 16'hFFF5, 16'h0000);

    // Underflow, then clear.
    peek("empty_fifo_read", 16'hFFF4, 16'h0000);
    rd_cyc(16'hFFF4);
    peek("und_status", 16'hFFF5, 16'h0020);
    wr_cyc(16'hFFF5, 16'hFFFF);
    peek("und_cleared", 16'hFFF5, 16'h0000);

    // Underflow-pop and push together on an empty FIFO.
    cycle(16'hFFF4, '0, 1'b0, 1'b1, 1'b1, 16'h0066, in_raw);
    peek("und_push_status", 16'hFFF5, 16'h0025);
    wr_cyc(16'hFFF5, 16'h0000);

    // Push and pop together at count=2.
    push_cyc(16'h0077);
    cycle(16'hFFF4, '0, 1'b0, 1'b1, 1'b1, 16'h0088, in_raw);
    peek("pushpop_status", 16'hFFF5, 16'h0009);
    rd_cyc(16'hFFF4);
    rd_cyc(16'hFFF4);

    // Synchroniser latency.
    cycle(16'h0000, '0, 1'b0, 1'b0, 1'b0, '0, 16'h1111);
    cycle(16'h0000, '0, 1'b0, 1'b0, 1'b0, '0, 16'h1111);
    cycle(16'h0000, '0, 1'b0, 1'b0, 1'b0, '0, 16'hBEEF);
    peek("sync_one_edge", 16'hFFF6, 16'h1111);
    cycle(16'h0000, '0, 1'b0, 1'b0, 1'b0, '0, 16'hBEEF);
    peek("sync_two_edges", 16'hFFF6, 16'hBEEF);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 9) < 8) a = {12'hFFF, 4'($urandom_range(0, 15))};
      else a = 16'($urandom);
      cycle(a, W'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 1) == 1), W'($urandom),
            ($urandom_range(0, 3) == 0) ? W'($urandom) : in_raw);
    end

    // Async reset mid-traffic with count=3 and out_reg0=0x00FF.
    wr_cyc(16'hFFF5, 16'h0000);
    for (int i = 0; i < 2 * D && m_q.size() > 0; i++) rd_cyc(16'hFFF4);
    wr_cyc(16'hFFF0, 16'h00FF);
    push_cyc(16'h0101);
    push_cyc(16'h0202);
    push_cyc(16'h0303);
    peek("pre_reset_status", 16'hFFF5, 16'h000D);
    check("pre_reset_out0", 64'(out_ports[15:0]), 64'(16'h00FF));
    direcciones = 16'hFFF5; re = 1'b1; we = 1'b0; in_valid = 1'b1; in_data = 16'h0404;
    #1;
    reset = 1'b0;
    #1;
    check("async_out_ports", out_ports, '0);
    check("async_status", 64'(datos), 64'(0));
    check("async_in_ready", 64'(in_ready), 64'(0));
    model_reset();
    re = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    peek("post_reset_status", 16'hFFF5, 16'h0000);
    rd_cyc(16'hFFF5);
    rd_cyc(16'hFFF0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
